// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg : shared constants and write-port arbitration for regfile_sb
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

  localparam int REG_ZERO       = 0;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;

  // Upper bounds the arbitration function is sized for; callers zero-extend.
  localparam int MAX_NW = 2;
  localparam int MAX_AW = 16;

  typedef struct packed {
    logic hit;
    logic sel;
  } wr_win_t;

  // Highest-numbered enabled port targeting idx wins; index 0 never hits.
  function automatic wr_win_t wr_winner(input logic [MAX_NW-1:0]        wen,
                                        input logic [MAX_NW*MAX_AW-1:0] waddr,
                                        input logic [MAX_AW-1:0]        idx);
    wr_win_t w;
    w = '0;
    for (int j = 0; j < MAX_NW; j++) begin
      if (wen[j] && (idx != MAX_AW'(REG_ZERO)) && (waddr[j*MAX_AW +: MAX_AW] == idx)) begin
        w.hit = 1'b1;
        w.sel = j[0];
      end
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_sb_if.sv
// ----------------------------------------------------------------------------
// regfile_sb_if : read, write, allocate and debug bus of regfile_sb
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface regfile_sb_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NR         = 2,
  parameter int NW         = 2
);
  localparam int NREG = 2**ADDR_WIDTH;

  logic [NR*ADDR_WIDTH-1:0] raddr;
  logic [NR*DATA_WIDTH-1:0] rdata;
  logic [NR-1:0]            rbusy;
  logic [NW-1:0]            wen;
  logic [NW*ADDR_WIDTH-1:0] waddr;
  logic [NW*DATA_WIDTH-1:0] wdata;
  logic                     alloc_valid;
  logic [ADDR_WIDTH-1:0]    alloc_addr;
  logic                     alloc_ready;
  logic [ADDR_WIDTH-1:0]    dbg_addr;
  logic [DATA_WIDTH-1:0]    dbg_data;
  logic [NREG-1:0]          busy_vec;

  modport master (
    output raddr, wen, waddr, wdata, alloc_valid, alloc_addr, dbg_addr,
    input  rdata, rbusy, alloc_ready, dbg_data, busy_vec
  );

  modport slave (
    input  raddr, wen, waddr, wdata, alloc_valid, alloc_addr, dbg_addr,
    output rdata, rbusy, alloc_ready, dbg_data, busy_vec
  );

endinterface

`default_nettype wire

// File: rtl/regfile_busy.sv
// ----------------------------------------------------------------------------
// regfile_busy : per-register busy scoreboard with allocation handshake
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module regfile_busy
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NW         = 2
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic [NW-1:0]            i_wen,
  input  wire logic [NW*ADDR_WIDTH-1:0] i_waddr,
  input  wire logic                     i_alloc_valid,
  input  wire logic [ADDR_WIDTH-1:0]    i_alloc_addr,
  output logic                          o_alloc_ready,
  output logic [2**ADDR_WIDTH-1:0]      o_busy_vec
);

  localparam int NREG = 2**ADDR_WIDTH;

  logic [MAX_NW-1:0]        w_wen_ext;
  logic [MAX_NW*MAX_AW-1:0] w_waddr_ext;
  logic [NREG-1:0]          w_hit;
  logic [NREG-1:0]          r_busy;
  logic                     w_fire;

  always_comb begin
    w_wen_ext   = '0;
    w_waddr_ext = '0;
    for (int j = 0; j < NW; j++) begin
      w_wen_ext[j]                        = i_wen[j];
      w_waddr_ext[j*MAX_AW +: MAX_AW]     = MAX_AW'(i_waddr[j*ADDR_WIDTH +: ADDR_WIDTH]);
    end
  end

  always_comb begin
    w_hit = '0;
    for (int r = 0; r < NREG; r++) begin
      w_hit[r] = wr_winner(w_wen_ext, w_waddr_ext, MAX_AW'(r)).hit;
    end
  end

  // A writeback landing this cycle frees the register for a new producer.
  assign o_alloc_ready = (i_alloc_addr == ADDR_WIDTH'(REG_ZERO))
                       | ~r_busy[i_alloc_addr]
                       | w_hit[i_alloc_addr];
  assign w_fire        = i_alloc_valid & o_alloc_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy[0] <= 1'b0;
      for (int r = 1; r < NREG; r++) begin
        if (w_fire && (i_alloc_addr == ADDR_WIDTH'(r))) begin
          r_busy[r] <= 1'b1;
        end else if (w_hit[r]) begin
          r_busy[r] <= 1'b0;
        end
      end
    end
  end

  assign o_busy_vec = r_busy;

endmodule

`default_nettype wire

// File: rtl/regfile_sb.sv
// ----------------------------------------------------------------------------
// regfile_sb : multi-port register file with write bypass and busy scoreboard
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module regfile_sb
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NR         = 2,
  parameter int NW         = 2,
  parameter int BYPASS     = 1
) (
  input  wire logic clk,
  input  wire logic rst,
  regfile_sb_if.slave bus
);

  localparam int NREG = 2**ADDR_WIDTH;

  logic [MAX_NW-1:0]        w_wen_ext;
  logic [MAX_NW*MAX_AW-1:0] w_waddr_ext;
  wr_win_t                  w_win [NREG];
  logic [DATA_WIDTH-1:0]    r_rf  [NREG];
  logic [NREG-1:0]          w_busy;

  always_comb begin
    w_wen_ext   = '0;
    w_waddr_ext = '0;
    for (int j = 0; j < NW; j++) begin
      w_wen_ext[j]                    = bus.wen[j];
      w_waddr_ext[j*MAX_AW +: MAX_AW] = MAX_AW'(bus.waddr[j*ADDR_WIDTH +: ADDR_WIDTH]);
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      w_win[r] = wr_winner(w_wen_ext, w_waddr_ext, MAX_AW'(r));
    end
  end

  // Entry 0 is only ever reset, so it stays a constant zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        r_rf[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (w_win[r].hit) begin
          r_rf[r] <= bus.wdata[int'(w_win[r].sel)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  generate
    for (genvar i = 0; i < NR; i++) begin : g_rd
      logic [ADDR_WIDTH-1:0] w_ra;
      wr_win_t               w_rwin;
      logic                  w_byp;

      assign w_ra   = bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_rwin = w_win[w_ra];
      assign w_byp  = (BYPASS != 0) && w_rwin.hit;

      // Bypass data must not leak out while reset holds the array clear.
      assign bus.rdata[i*DATA_WIDTH +: DATA_WIDTH] =
          (rst || (w_ra == ADDR_WIDTH'(REG_ZERO))) ? '0 :
          w_byp ? bus.wdata[int'(w_rwin.sel)*DATA_WIDTH +: DATA_WIDTH] :
                  r_rf[w_ra];
      assign bus.rbusy[i] = w_busy[w_ra] & ~w_byp;
    end
  endgenerate

  assign bus.dbg_data = (rst || (bus.dbg_addr == ADDR_WIDTH'(REG_ZERO))) ? '0 : r_rf[bus.dbg_addr];

  regfile_busy #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NW         (NW)
  ) u_busy (
    .clk           (clk),
    .rst           (rst),
    .i_wen         (bus.wen),
    .i_waddr       (bus.waddr),
    .i_alloc_valid (bus.alloc_valid),
    .i_alloc_addr  (bus.alloc_addr),
    .o_alloc_ready (bus.alloc_ready),
    .o_busy_vec    (w_busy)
  );

  assign bus.busy_vec = w_busy;

endmodule

`default_nettype wire

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port integer register file with write-port priority, optional write-to-read bypass, and a per-register busy scoreboard for multi-cycle producers. It replaces the single-write, two-read EXU register file. It serves NR operand reads per cycle, NW writebacks per cycle, and a debug read port for the simulation harness.

## Interface
- ADDR_WIDTH, 5, register index width; depth NREG = 2**ADDR_WIDTH
- DATA_WIDTH, 32, register width
- NR, 2, number of read ports (1..4)
- NW, 2, number of write ports (1..2)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see the pre-edge value
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- raddr  in  NR*ADDR_WIDTH  read indices, port i at slice i
- rdata  out  NR*DATA_WIDTH  read data, combinational
- rbusy  out  NR  read port i targets a register with a pending producer
- wen  in  NW  write enable per port
- waddr  in  NW*ADDR_WIDTH  write indices
- wdata  in  NW*DATA_WIDTH  write data
- alloc_valid  in  1  request to mark a destination busy
- alloc_addr  in  ADDR_WIDTH  destination to mark
- alloc_ready  out  1  allocation accepted this cycle
- dbg_addr  in  ADDR_WIDTH  debug read index
- dbg_data  out  DATA_WIDTH  debug read data, no bypass
- busy_vec  out  NREG  busy bits, bit 0 always 0

## Operation
- Register 0 reads 0, is never busy, and ignores writes and allocations. alloc_ready is 1 for alloc_addr == 0, with no effect.
- Reset clears all registers to 0 and all busy bits to 0 immediately, independent of clk.
  - While rst is high: rdata = 0, dbg_data = 0, rbusy = 0, busy_vec = 0.
  - Writes and allocs presented during reset are dropped.
- Write: on a clk rising edge with wen[j] and waddr[j] != 0, the register takes wdata[j].
  - If both ports hit the same index, port NW-1 (highest index) wins.
- Read: rdata[i] = rf[raddr[i]], or 0 for index 0.
  - With BYPASS=1, if any wen[j] hits raddr[i] (nonzero) in the same cycle, rdata[i] returns the winning port's wdata.
- Scoreboard: on a clk edge, busy[r] is set if the allocation fires on r.
  - Otherwise busy[r] is cleared if any wen hits r.
  - Otherwise it holds.
  - Alloc and write to the same r in the same cycle: busy ends at 1, because the new producer wins.
- alloc_ready = (alloc_addr == 0) | ~busy[alloc_addr] | (any wen hits alloc_addr this cycle).
  - An allocation fires when alloc_valid & alloc_ready.
  - alloc_ready does not depend on alloc_valid.
  - A WAW allocation on a busy register stalls until its writeback cycle.
- rbusy[i] = busy[raddr[i]] & ~(BYPASS & same-cycle write hit on raddr[i]).
  - A bypassed read is reported ready.
- Writes to a non-busy register are legal and leave busy at 0.

## Timing
- Read latency 0: rdata, rbusy and dbg_data are combinational from addresses, state and (if BYPASS) the write ports.
- Write latency 1: the value is visible to non-bypassed reads and to dbg_data the cycle after the edge.
- Scoreboard latency 1: after alloc fires on an edge, busy_vec and rbusy reflect it from the next cycle.
- Reset deassertion mid-operation: the first clk edge after deassertion is a normal edge.
- No other outputs have storage; all reset values are 0.

## Structure
- Package regfile_pkg holds:
  - constants REG_ZERO = 0 and default ADDR_WIDTH/DATA_WIDTH;
  - a function that resolves the winning write port for an index, shared by the bypass and scoreboard-clear logic.
- Sub-module regfile_busy holds the NREG-bit scoreboard: set/clear/priority logic and alloc_ready.
- The data array and the read/bypass muxing stay in regfile_sb.

## Test plan
- Reset, then write x5=0x1234 via port 0. Read x5 the same cycle with BYPASS=1 -> 0x1234; with BYPASS=0 -> 0. Next cycle, both settings -> 0x1234.
- wen=2'b11, both ports waddr=7, wdata0=0xAAAA, wdata1=0x5555 -> x7 = 0x5555; the bypass read the same cycle also returns 0x5555.
- Write x0=0xFFFF, then allocate x0 -> reads of x0 return 0, busy_vec[0] stays 0, alloc_ready=1.
- Allocate x3 -> busy_vec[3]=1 and rbusy=1 on a read of x3.
  - A second alloc on x3 -> alloc_ready=0.
  - Then write x3=9 and re-alloc x3 in the same cycle -> alloc fires, x3 = 9, busy_vec[3] stays 1.
- Allocate x4, then write x4=0x42 -> in the write cycle a read of x4 gives rbusy=0 and rdata=0x42 (BYPASS=1). busy_vec[4]=0 the next cycle.
- Fill x1..x31 with nonzero values and mark several busy, then pulse rst between clk edges -> all registers read 0, busy_vec=0, dbg_data=0 immediately. The first write after release succeeds.
